// File: rtl/alu_packet_parser.sv
// alu_packet_parser
// Byte-stream front end for the ALU. Parses a header of opcode, reserved
// byte and 16-bit little-endian length, where the length counts the whole
// packet. The payload is then either:
//   - assembled into 32-bit little-endian operands (ADD/MUL/DIV),
//   - forwarded untouched on the echo stream, or
//   - discarded, with a one-cycle error pulse.
module alu_packet_parser #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    OPERAND_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ECHO_OPCODE   = 8'hEC
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [OPERAND_WIDTH-1:0] m_op_tdata,
    output logic                     m_op_tvalid,
    input  logic                     m_op_tready,
    output logic                     m_op_tfirst,
    output logic                     m_op_tlast,
    output logic [1:0]               m_op_code,
    output logic [DATA_WIDTH-1:0]    m_echo_tdata,
    output logic                     m_echo_tvalid,
    input  logic                     m_echo_tready,
    output logic                     m_echo_tlast,
    output logic                     err_opcode_o,
    output logic                     err_len_o
);

    // Parser states
    localparam logic [2:0] ST_OPCODE   = 3'd0;
    localparam logic [2:0] ST_RESERVED = 3'd1;
    localparam logic [2:0] ST_LEN_LSB  = 3'd2;
    localparam logic [2:0] ST_LEN_MSB  = 3'd3;
    localparam logic [2:0] ST_ECHO     = 3'd4;
    localparam logic [2:0] ST_OPERAND  = 3'd5;
    localparam logic [2:0] ST_DISCARD  = 3'd6;

    // Registered state
    logic [2:0]                state_r;
    logic [DATA_WIDTH-1:0]     opcode_r;
    logic [7:0]                len_lsb_r;
    logic [15:0]               rem_r;
    logic [1:0]                byte_cnt_r;
    logic [3*DATA_WIDTH-1:0]   asm_r;
    logic                      first_pend_r;
    logic [OPERAND_WIDTH-1:0]  op_data_r;
    logic                      op_valid_r;
    logic                      op_first_r;
    logic                      op_last_r;
    logic [1:0]                op_code_r;
    logic                      err_opcode_r;
    logic                      err_len_r;

    // Next-state values
    logic [2:0]                nxt_state_s;
    logic [DATA_WIDTH-1:0]     nxt_opcode_s;
    logic [7:0]                nxt_len_lsb_s;
    logic [15:0]               nxt_rem_s;
    logic [1:0]                nxt_byte_cnt_s;
    logic [3*DATA_WIDTH-1:0]   nxt_asm_s;
    logic                      nxt_first_pend_s;
    logic [OPERAND_WIDTH-1:0]  nxt_op_data_s;
    logic                      nxt_op_valid_s;
    logic                      nxt_op_first_s;
    logic                      nxt_op_last_s;
    logic [1:0]                nxt_op_code_s;
    logic                      nxt_err_opcode_s;
    logic                      nxt_err_len_s;

    // Helper decode
    logic                      ready_s;
    logic                      accept_s;
    logic [15:0]               len_s;
    logic [15:0]               rem_calc_s;
    logic [15:0]               rem_dec_s;
    logic                      len_short_s;
    logic                      rem_zero_s;
    logic                      rem_bad_s;
    logic                      is_echo_s;
    logic                      is_arith_s;
    logic [OPERAND_WIDTH-1:0]  word_s;

    assign accept_s    = s_axis_tvalid & ready_s;
    assign len_s       = {s_axis_tdata[7:0], len_lsb_r};
    assign len_short_s = (len_s < 16'd4);
    assign rem_calc_s  = len_short_s ? 16'd0 : (len_s - 16'd4);
    assign rem_zero_s  = (rem_calc_s == 16'd0);
    assign rem_bad_s   = (rem_calc_s < 16'd8) || (rem_calc_s[1:0] != 2'b00);
    // The remaining count saturates at zero instead of wrapping
    assign rem_dec_s   = (rem_r == 16'd0) ? 16'd0 : (rem_r - 16'd1);
    assign is_echo_s   = (opcode_r == ECHO_OPCODE);
    // Opcodes 1..3 select ADD/MUL/DIV; upper bits must be clear
    assign is_arith_s  = (opcode_r[DATA_WIDTH-1:2] == '0) && (opcode_r[1:0] != 2'b00);
    // Fourth byte completes the little-endian word together with bytes 0..2
    assign word_s      = {s_axis_tdata, asm_r};

    // Input ready: echo mirrors the TX side, operand stalls only the word-completing byte
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_OPCODE, ST_RESERVED, ST_LEN_LSB, ST_LEN_MSB: begin
                ready_s = 1'b1;
            end
            ST_ECHO: begin
                ready_s = m_echo_tready;
            end
            ST_OPERAND: begin
                if ((byte_cnt_r == 2'd3) && op_valid_r && !m_op_tready) begin
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            ST_DISCARD: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Parser next-state, operand assembly and output-register update
    always_comb begin
        nxt_state_s      = state_r;
        nxt_opcode_s     = opcode_r;
        nxt_len_lsb_s    = len_lsb_r;
        nxt_rem_s        = rem_r;
        nxt_byte_cnt_s   = byte_cnt_r;
        nxt_asm_s        = asm_r;
        nxt_first_pend_s = first_pend_r;
        nxt_op_data_s    = op_data_r;
        nxt_op_first_s   = op_first_r;
        nxt_op_last_s    = op_last_r;
        nxt_op_code_s    = op_code_r;
        nxt_err_opcode_s = 1'b0;
        nxt_err_len_s    = 1'b0;

        // A held operand drops once taken; a reload below overrides this
        if (op_valid_r && m_op_tready) begin
            nxt_op_valid_s = 1'b0;
        end else begin
            nxt_op_valid_s = op_valid_r;
        end

        case (state_r)
            ST_OPCODE: begin
                if (accept_s) begin
                    nxt_opcode_s = s_axis_tdata;
                    nxt_state_s  = ST_RESERVED;
                end else begin
                    nxt_state_s  = ST_OPCODE;
                end
            end
            ST_RESERVED: begin
                if (accept_s) begin
                    nxt_state_s = ST_LEN_LSB;
                end else begin
                    nxt_state_s = ST_RESERVED;
                end
            end
            ST_LEN_LSB: begin
                if (accept_s) begin
                    nxt_len_lsb_s = s_axis_tdata[7:0];
                    nxt_state_s   = ST_LEN_MSB;
                end else begin
                    nxt_state_s   = ST_LEN_LSB;
                end
            end
            ST_LEN_MSB: begin
                if (accept_s) begin
                    nxt_rem_s      = rem_calc_s;
                    nxt_byte_cnt_s = 2'd0;
                    nxt_err_len_s  = len_short_s;
                    if (is_echo_s) begin
                        nxt_state_s = rem_zero_s ? ST_OPCODE : ST_ECHO;
                    end else if (is_arith_s) begin
                        if (rem_bad_s) begin
                            nxt_err_len_s = 1'b1;
                            nxt_state_s   = rem_zero_s ? ST_OPCODE : ST_DISCARD;
                        end else begin
                            nxt_first_pend_s = 1'b1;
                            nxt_state_s      = ST_OPERAND;
                        end
                    end else begin
                        nxt_err_opcode_s = 1'b1;
                        nxt_state_s      = rem_zero_s ? ST_OPCODE : ST_DISCARD;
                    end
                end else begin
                    nxt_state_s = ST_LEN_MSB;
                end
            end
            ST_ECHO: begin
                if (accept_s) begin
                    nxt_rem_s = rem_dec_s;
                    if (rem_r == 16'd1) begin
                        nxt_state_s = ST_OPCODE;
                    end else begin
                        nxt_state_s = ST_ECHO;
                    end
                end else begin
                    nxt_state_s = ST_ECHO;
                end
            end
            ST_OPERAND: begin
                if (accept_s) begin
                    nxt_rem_s = rem_dec_s;
                    if (byte_cnt_r == 2'd3) begin
                        nxt_op_data_s    = word_s;
                        nxt_op_valid_s   = 1'b1;
                        nxt_op_first_s   = first_pend_r;
                        nxt_op_last_s    = (rem_r == 16'd1);
                        nxt_op_code_s    = opcode_r[1:0];
                        nxt_first_pend_s = 1'b0;
                        nxt_byte_cnt_s   = 2'd0;
                        if (rem_r == 16'd1) begin
                            nxt_state_s = ST_OPCODE;
                        end else begin
                            nxt_state_s = ST_OPERAND;
                        end
                    end else begin
                        nxt_byte_cnt_s = byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0:    nxt_asm_s[DATA_WIDTH-1:0]              = s_axis_tdata;
                            2'd1:    nxt_asm_s[2*DATA_WIDTH-1:DATA_WIDTH]   = s_axis_tdata;
                            2'd2:    nxt_asm_s[3*DATA_WIDTH-1:2*DATA_WIDTH] = s_axis_tdata;
                            default: nxt_asm_s                              = asm_r;
                        endcase
                    end
                end else begin
                    nxt_state_s = ST_OPERAND;
                end
            end
            ST_DISCARD: begin
                if (accept_s) begin
                    nxt_rem_s = rem_dec_s;
                    if (rem_r == 16'd1) begin
                        nxt_state_s = ST_OPCODE;
                    end else begin
                        nxt_state_s = ST_DISCARD;
                    end
                end else begin
                    nxt_state_s = ST_DISCARD;
                end
            end
            default: begin
                nxt_state_s = ST_OPCODE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= ST_OPCODE;
            opcode_r     <= '0;
            len_lsb_r    <= 8'd0;
            rem_r        <= 16'd0;
            byte_cnt_r   <= 2'd0;
            asm_r        <= '0;
            first_pend_r <= 1'b0;
            op_data_r    <= '0;
            op_valid_r   <= 1'b0;
            op_first_r   <= 1'b0;
            op_last_r    <= 1'b0;
            op_code_r    <= 2'd0;
            err_opcode_r <= 1'b0;
            err_len_r    <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            opcode_r     <= nxt_opcode_s;
            len_lsb_r    <= nxt_len_lsb_s;
            rem_r        <= nxt_rem_s;
            byte_cnt_r   <= nxt_byte_cnt_s;
            asm_r        <= nxt_asm_s;
            first_pend_r <= nxt_first_pend_s;
            op_data_r    <= nxt_op_data_s;
            op_valid_r   <= nxt_op_valid_s;
            op_first_r   <= nxt_op_first_s;
            op_last_r    <= nxt_op_last_s;
            op_code_r    <= nxt_op_code_s;
            err_opcode_r <= nxt_err_opcode_s;
            err_len_r    <= nxt_err_len_s;
        end
    end

    assign s_axis_tready = ready_s;
    assign m_op_tdata    = op_data_r;
    assign m_op_tvalid   = op_valid_r;
    assign m_op_tfirst   = op_first_r;
    assign m_op_tlast    = op_last_r;
    assign m_op_code     = op_code_r;
    // Echo is a zero-latency pass-through of the input stream
    assign m_echo_tdata  = s_axis_tdata;
    assign m_echo_tvalid = (state_r == ST_ECHO) && s_axis_tvalid;
    assign m_echo_tlast  = (state_r == ST_ECHO) && (rem_r == 16'd1);
    assign err_opcode_o  = err_opcode_r;
    assign err_len_o     = err_len_r;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed testbench for alu_packet_parser. Inputs change 2 time units after
// the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_alu_packet_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] op_data;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic        op_first;
    logic        op_last;
    logic [1:0]  op_code;
    logic [7:0]  echo_data;
    logic        echo_valid;
    logic        echo_ready = 1'b1;
    logic        echo_last;
    logic        err_op;
    logic        err_len;

    int n_total = 0;
    int n_bad = 0;
    int err_op_cnt = 0;
    int err_len_cnt = 0;
    int byte_idx = 0;
    int stall_lo = 1000;
    int stall_hi = -1;
    logic track_stall = 1'b0;

    logic [35:0] op_q[$];    // {code, first, last, data}
    logic [8:0]  echo_q[$];  // {last, data}
    logic [7:0]  pkt[$];

    always #5 clk = ~clk;

    alu_packet_parser dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_op_tdata    (op_data),
        .m_op_tvalid   (op_valid),
        .m_op_tready   (op_ready),
        .m_op_tfirst   (op_first),
        .m_op_tlast    (op_last),
        .m_op_code     (op_code),
        .m_echo_tdata  (echo_data),
        .m_echo_tvalid (echo_valid),
        .m_echo_tready (echo_ready),
        .m_echo_tlast  (echo_last),
        .err_opcode_o  (err_op),
        .err_len_o     (err_len)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Collect completed transfers, error pulses and input stalls
    always @(negedge clk) begin
        if (op_valid && op_ready) op_q.push_back({op_code, op_first, op_last, op_data});
        if (echo_valid && echo_ready) echo_q.push_back({echo_last, echo_data});
        if (echo_valid) chk("echo_ready_mirror", {31'd0, s_tready}, {31'd0, echo_ready});
        if (err_op) err_op_cnt <= err_op_cnt + 1;
        if (err_len) err_len_cnt <= err_len_cnt + 1;
        if (!track_stall) begin
            stall_lo <= 1000;
            stall_hi <= -1;
        end else if (s_tvalid && !s_tready) begin
            if (byte_idx < stall_lo) stall_lo <= byte_idx;
            if (byte_idx > stall_hi) stall_hi <= byte_idx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called 2 units after a rising edge; returns likewise after the transfer
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) chk("byte_timeout", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #2;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            byte_idx = i;
            send_byte(pkt[i]);
        end
    endtask

    task automatic expect_op(input string tag, input int idx, input logic [31:0] d,
                             input logic [1:0] c, input logic f, input logic l);
        if (idx < op_q.size()) begin
            chk({tag, "_data"}, op_q[idx][31:0], d);
            chk({tag, "_ctl"}, {28'd0, op_q[idx][35:32]}, {28'd0, c, f, l});
        end else begin
            chk({tag, "_missing"}, op_q.size(), idx + 1);
        end
    endtask

    task automatic expect_echo(input string tag, input int idx, input logic [8:0] e);
        if (idx < echo_q.size()) begin
            chk(tag, {23'd0, echo_q[idx]}, {23'd0, e});
        end else begin
            chk({tag, "_missing"}, echo_q.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int ob;
        int eb;
        int eo;
        int el;

        // Reset state
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valids", {28'd0, op_valid, echo_valid, err_op, err_len}, 32'd0);
        chk("rst_data", op_data, 32'd0);
        chk("rst_ctl", {29'd0, op_code, op_first | op_last}, 32'd0);
        chk("rst_ready", {31'd0, s_tready}, 32'd1);
        tick(1);

        // ADD, two operands
        ob = op_q.size(); eo = err_op_cnt; el = err_len_cnt;
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(5);
        chk("add_count", op_q.size() - ob, 32'd2);
        expect_op("add0", ob, 32'h00000005, 2'b01, 1'b1, 1'b0);
        expect_op("add1", ob + 1, 32'h00000007, 2'b01, 1'b0, 1'b1);
        chk("add_errs", (err_op_cnt - eo) + (err_len_cnt - el), 32'd0);

        // Echo with toggling TX ready
        ob = op_q.size(); eb = echo_q.size();
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        fork
            send_pkt();
            begin
                repeat (20) begin
                    @(posedge clk);
                    #2;
                    echo_ready = ~echo_ready;
                end
            end
        join
        echo_ready = 1'b1;
        tick(3);
        chk("echo_count", echo_q.size() - eb, 32'd3);
        expect_echo("echo0", eb, 9'h041);
        expect_echo("echo1", eb + 1, 9'h042);
        expect_echo("echo2", eb + 2, 9'h143);
        chk("echo_no_op", op_q.size() - ob, 32'd0);

        // MUL with backpressure on the operand output
        ob = op_q.size();
        pkt = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                8'hFF, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        op_ready = 1'b0;
        track_stall = 1'b1;
        fork
            send_pkt();
            begin
                repeat (10) @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("hold_data", op_data, 32'h11223344);
                    chk("hold_ctl", {27'd0, op_valid, op_first, op_last, op_code}, {27'd0, 1'b1, 1'b1, 1'b0, 2'b10});
                end
                @(posedge clk);
                #2;
                op_ready = 1'b1;
            end
        join
        tick(5);
        chk("bp_stall_lo", stall_lo, 32'd11);
        chk("bp_stall_hi", stall_hi, 32'd11);
        track_stall = 1'b0;
        chk("bp_count", op_q.size() - ob, 32'd3);
        expect_op("bp0", ob, 32'h11223344, 2'b10, 1'b1, 1'b0);
        expect_op("bp1", ob + 1, 32'h0000FFFF, 2'b10, 1'b0, 1'b0);
        expect_op("bp2", ob + 2, 32'h00000002, 2'b10, 1'b0, 1'b1);

        // Unknown opcode followed by a good ADD
        ob = op_q.size(); eb = echo_q.size(); eo = err_op_cnt; el = err_len_cnt;
        pkt = '{8'h7F, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'h01, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(5);
        chk("unk_err_op", err_op_cnt - eo, 32'd1);
        chk("unk_err_len", err_len_cnt - el, 32'd0);
        chk("unk_no_echo", echo_q.size() - eb, 32'd0);
        chk("unk_count", op_q.size() - ob, 32'd2);
        expect_op("unk_add0", ob, 32'h00000001, 2'b01, 1'b1, 1'b0);
        expect_op("unk_add1", ob + 1, 32'h00000002, 2'b01, 1'b0, 1'b1);

        // Bad length: payload of 6 is discarded
        ob = op_q.size(); eo = err_op_cnt; el = err_len_cnt;
        pkt = '{8'h02, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt();
        tick(5);
        chk("badlen_err_len", err_len_cnt - el, 32'd1);
        chk("badlen_err_op", err_op_cnt - eo, 32'd0);
        chk("badlen_no_op", op_q.size() - ob, 32'd0);

        // Length 2: error, then the very next byte is an opcode
        el = err_len_cnt;
        pkt = '{8'h02, 8'h00, 8'h02, 8'h00,
                8'h01, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(5);
        chk("len2_err_len", err_len_cnt - el, 32'd1);
        chk("len2_count", op_q.size() - ob, 32'd2);
        expect_op("len2_add0", ob, 32'h00000009, 2'b01, 1'b1, 1'b0);
        expect_op("len2_add1", ob + 1, 32'h0000000A, 2'b01, 1'b0, 1'b1);

        // Reset in the middle of the second operand
        ob = op_q.size();
        op_ready = 1'b0;
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_pkt();
        @(negedge clk);
        chk("pre_reset_valid", {31'd0, op_valid}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valids", {28'd0, op_valid, echo_valid, err_op, err_len}, 32'd0);
        chk("mid_rst_data", op_data, 32'd0);
        chk("mid_rst_ready", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #2;
        op_ready = 1'b1;
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(5);
        chk("post_rst_count", op_q.size() - ob, 32'd2);
        expect_op("post_rst0", ob, 32'h00000003, 2'b01, 1'b1, 1'b0);
        expect_op("post_rst1", ob + 1, 32'h00000004, 2'b01, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_packet_parser.md
Name: alu_packet_parser

Overview:
- Front-end stage between the UART receive AXI-stream (8-bit bytes) and the ALU datapath.
- Parses the byte packet format: opcode, reserved, length LSB, length MSB, payload. Length counts the whole packet, header included.
- For arithmetic packets, assembles little-endian 32-bit operands and presents them one per beat with first/last markers and the decoded opcode.
- For echo packets, forwards payload bytes unchanged on a separate byte stream. Malformed or unknown packets are discarded and flagged.

Parameters:
- DATA_WIDTH, 8, byte width of the input stream and the echo stream.
- OPERAND_WIDTH, 32, operand width. Must equal 4*DATA_WIDTH.
- ECHO_OPCODE, 8'hEC, opcode selecting echo.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous active-high reset.
- s_axis_tdata  input  DATA_WIDTH  received byte.
- s_axis_tvalid  input  1  received byte valid.
- s_axis_tready  output  1  byte accepted when tvalid&tready.
- m_op_tdata  output  OPERAND_WIDTH  assembled operand.
- m_op_tvalid  output  1  operand valid.
- m_op_tready  input  1  consumer accepts operand.
- m_op_tfirst  output  1  first operand of packet.
- m_op_tlast  output  1  last operand of packet.
- m_op_code  output  2  01=ADD, 10=MUL, 11=DIV. Stable while m_op_tvalid.
- m_echo_tdata  output  DATA_WIDTH  echo payload byte.
- m_echo_tvalid  output  1  echo byte valid.
- m_echo_tready  input  1  downstream (TX) ready.
- m_echo_tlast  output  1  final echo payload byte.
- err_opcode_o  output  1  one-cycle pulse: unknown opcode.
- err_len_o  output  1  one-cycle pulse: illegal length.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high (reset_i), and dominates all other inputs in that cycle.
- Reset values:
  - State = OPCODE.
  - m_op_tvalid, m_op_tfirst, m_op_tlast, m_echo_tvalid, err_* = 0.
  - m_op_tdata, m_op_code = 0.
  - Byte counter and remaining-length counter = 0.
  - A partial operand or packet is dropped. The first byte after reset deasserts is an opcode.
- States: OPCODE, RESERVED, LEN_LSB, LEN_MSB, ECHO, OPERAND, DISCARD.
- Header states (OPCODE, RESERVED, LEN_LSB, LEN_MSB):
  - s_axis_tready=1. Each advances one state per accepted byte.
  - OPCODE latches the opcode. RESERVED ignores its byte.
- Leaving LEN_MSB, with 16-bit length L and remaining count R=L-4 (R=0 if L<4):
  - Echo opcode: R==0 -> OPCODE. Else -> ECHO.
  - Opcode 01/02/03: R<8 or R[1:0]!=0 -> err_len_o pulse, then DISCARD (or OPCODE if R==0). Else -> OPERAND.
  - Any other opcode: err_opcode_o pulse, then DISCARD (or OPCODE if R==0).
  - L<4 additionally pulses err_len_o.
- ECHO:
  - Zero-latency combinational pass-through: m_echo_tdata=s_axis_tdata, m_echo_tvalid=s_axis_tvalid, s_axis_tready=m_echo_tready.
  - R decrements per transfer. m_echo_tlast = (R==1). After the last transfer -> OPCODE.
- OPERAND:
  - Bytes fill the assembly register little-endian: byte k goes to bits [8k+7:8k], with 2-bit byte counter k.
  - On the 4th byte (k==3) the full word loads the output register the same cycle. m_op_tvalid rises the next cycle.
  - m_op_tfirst=1 for the packet's first operand. m_op_tlast=1 when that word consumed the final R bytes.
  - Bytes 0-2 are accepted while the output is still held.
  - s_axis_tready=0 only when k==3 and m_op_tvalid and !m_op_tready, so the output register is never overwritten before acceptance.
  - Accept and reload may occur in the same cycle, giving back-to-back operands at full rate.
  - After loading the last word -> OPCODE. m_op_tvalid persists until accepted, independent of state.
- DISCARD: s_axis_tready=1. R decrements per byte. At R==1 accepted -> OPCODE.
- Output stability: m_op_tdata, m_op_code, m_op_tfirst and m_op_tlast are held while m_op_tvalid & !m_op_tready.
- Counter widths:
  - R is 16-bit and never wraps: decrement only on accepted bytes, minimum 0.
  - Length FFFF is legal: R=FFFB, discarded if not a multiple of 4.
- Next header while output held: after the last operand, header bytes of the next packet may be parsed while it is still held. Its first 4th-byte load stalls as above.
- Error pulses last exactly one cycle, asserted in the cycle after the LEN_MSB byte is accepted.

Test Plan:
- ADD with two operands: bytes 01 00 0C 00 05 00 00 00 07 00 00 00, m_op_tready=1 -> two beats: 0x00000005 (first=1, last=0, code=01), then 0x00000007 (first=0, last=1). No error pulses.
- Echo: EC 00 07 00 41 42 43, m_echo_tready toggling 1/0 -> echo bytes 41, 42, 43 in order, tlast only on 43. s_axis_tready mirrors m_echo_tready. Then returns to OPCODE.
- Backpressure: MUL packet with three operands 0x11223344, 0x0000FFFF, 0x00000002, m_op_tready held 0 for 10 cycles:
  - First word stays stable.
  - s_axis_tready drops only on byte 3 of operand 2.
  - After release, all three words are delivered in order with correct first/last.
- Unknown opcode: 7F 00 08 00 AA BB CC DD, then ADD packet 01 00 0C 00 (1) (2) -> err_opcode_o pulses once. AA..DD are consumed with no output. The ADD operands 1 and 2 are delivered normally.
- Bad length: 02 00 0A 00 + 6 bytes -> err_len_o pulses once, 6 bytes discarded, no m_op_tvalid. Separately, length 0002 -> err_len_o and immediate return to OPCODE.
- Reset mid-operand: assert reset_i after byte 2 of an operand -> next cycle all valids are 0 and state is OPCODE. A following complete ADD packet parses correctly.
